rr_burst_arbiter: RTL and testbench

- Round-robin arbiter for one shared resource, e.g. a shared FIFO write port or bus slave, used by N requesters.
- Each grant is held for a burst of accepted beats. The grant ends on the requester's last beat, or when a per-grant beat limit is reached.
- Sits between the requester front-ends and the resource. The resource's per-beat acceptance (ack) drives the burst counter.
- Sequential: registered one-hot grant, rotating priority pointer, beat counter, IDLE/BUSY state machine.

---
 rtl/rr_burst_arbiter.sv | 137 +++++++++++++
 tb/tb_rr_burst_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter for one shared resource.
// A grant is held for a burst of accepted beats (ack & req[g]). It ends on the
// requester's last beat, at the per-grant beat limit, or when the requester
// drops req. Re-arbitration happens in the release cycle, so consecutive
// grants follow each other without an idle cycle.
module rr_burst_arbiter #(
    parameter int N         = 8,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = $clog2(MAX_BURST + 1),
    parameter int IDW       = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     last,
    input  logic             ack,
    output logic [N-1:0]     gnt,
    output logic [IDW-1:0]   gnt_id,
    output logic             busy,
    output logic [CNT_W-1:0] beat_cnt
);

    localparam logic [0:0]       S_IDLE   = 1'b0;
    localparam logic [0:0]       S_BUSY   = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [IDW-1:0]   ID_TOP   = IDW'(N - 1);

    logic [0:0]       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]   ptr_q, ptr_d;

    logic             req_g, last_g, beat, rel;
    logic [IDW-1:0]   next_start, scan_start, win;
    logic             found;
    logic [N-1:0]     win_oh;

    // Returns {found, index} of the first set bit of r scanning s, s+1, ...,
    // N-1, 0, ..., s-1. Bits at or above s are tried first; if none is set the
    // lowest set bit overall is the wrap-around winner.
    function automatic logic [IDW:0] rr_pick(input logic [N-1:0] r,
                                             input logic [IDW-1:0] s);
        logic [N-1:0]   hi;
        logic [IDW-1:0] w_hi;
        logic [IDW-1:0] w_all;
        for (int i = 0; i < N; i++) begin
            hi[i] = r[i] && (i >= int'(s));
        end
        w_hi  = '0;
        w_all = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hi[i]) w_hi  = IDW'(i);
            if (r[i])  w_all = IDW'(i);
        end
        if (|hi) return {1'b1, w_hi};
        return {|r, w_all};
    endfunction

    // Beat/release qualification for the current holder and the arbitration pick.
    always_comb begin
        req_g      = req[id_q];
        last_g     = last[id_q];
        beat       = ack && req_g;
        rel        = (state_q == S_BUSY) &&
                     (!req_g || (beat && (last_g || (cnt_q == CNT_LAST))));
        next_start = (id_q == ID_TOP) ? '0 : id_q + 1'b1;
        // While busy the holder is always scanned last; in IDLE the stored pointer applies.
        scan_start = (state_q == S_BUSY) ? next_start : ptr_q;
        {found, win} = rr_pick(req, scan_start);
        win_oh     = {{(N-1){1'b0}}, 1'b1} << win;
    end

    // Next-state logic for the IDLE/BUSY controller, grant, counter and pointer.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_BUSY;
                    gnt_d   = win_oh;
                    id_d    = win;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (rel) begin
                    ptr_d = next_start;
                    cnt_d = '0;
                    if (found) begin
                        gnt_d = win_oh;
                        id_d  = win;
                    end else begin
                        state_d = S_IDLE;
                        gnt_d   = '0;
                        id_d    = '0;
                        busy_d  = 1'b0;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // State registers; asynchronous reset clears everything and restarts the pointer at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt      = gnt_q;
    assign gnt_id   = id_q;
    assign busy     = busy_q;
    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Scoreboard bench for rr_burst_arbiter (N=8, MAX_BURST=4).
module tb_rr_burst_arbiter;

    localparam int N         = 8;
    localparam int MAX_BURST = 4;
    localparam int CNT_W     = $clog2(MAX_BURST + 1);
    localparam int IDW       = $clog2(N);

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N-1:0]     last;
    logic             ack;
    logic [N-1:0]     gnt;
    logic [IDW-1:0]   gnt_id;
    logic             busy;
    logic [CNT_W-1:0] beat_cnt;

    rr_burst_arbiter #(.N(N), .MAX_BURST(MAX_BURST)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .last     (last),
        .ack      (ack),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .busy     (busy),
        .beat_cnt (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] gnt;
        logic [31:0] id;
        logic [31:0] busy;
        logic [31:0] cnt;
        logic [31:0] ptr;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit m_busy;
    int m_g;
    int m_cnt;
    int m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int k);
        return ((v >> k) & 1) != 0;
    endfunction

    function automatic int scan(input logic [N-1:0] r, input int s);
        for (int i = 0; i < N; i++) begin
            if (bit_of(r, (s + i) % N)) return (s + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_g    = 0;
        m_cnt  = 0;
        m_ptr  = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l, input logic a);
        int  w;
        bit  bt;
        bit  rl;
        if (!m_busy) begin
            w = scan(r, m_ptr);
            if (w >= 0) begin
                m_busy = 1'b1;
                m_g    = w;
                m_cnt  = 0;
            end
        end else begin
            bt = a && bit_of(r, m_g);
            rl = !bit_of(r, m_g) || (bt && (bit_of(l, m_g) || m_cnt == MAX_BURST - 1));
            if (rl) begin
                m_ptr = (m_g + 1) % N;
                m_cnt = 0;
                w = scan(r, m_ptr);
                if (w >= 0) m_g = w;
                else m_busy = 1'b0;
            end else if (bt) begin
                m_cnt++;
            end
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "_gnt"},  32'(gnt),      e.gnt);
        chk({e.tag, "_busy"}, 32'(busy),     e.busy);
        chk({e.tag, "_cnt"},  32'(beat_cnt), e.cnt);
        chk({e.tag, "_ptr"},  32'(dut.ptr_q), e.ptr);
        if (e.busy != 0) chk({e.tag, "_id"}, 32'(gnt_id), e.id);
        chk({e.tag, "_onehot"}, 32'($onehot0(gnt)), 32'd1);
    endtask

    // drive one cycle of inputs, record model expectation, compare after the edge
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic a,
                        input string tag);
        exp_t e;
        req  = r;
        last = l;
        ack  = a;
        model_step(r, l, a);
        e.tag  = tag;
        e.gnt  = m_busy ? (32'd1 << m_g) : 32'd0;
        e.id   = 32'(m_g);
        e.busy = {31'd0, m_busy};
        e.cnt  = 32'(m_cnt);
        e.ptr  = 32'(m_ptr);
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic do_reset();
        req   = '0;
        last  = '0;
        ack   = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_gnt",  32'(gnt),      32'd0);
        chk("rst_busy", 32'(busy),     32'd0);
        chk("rst_cnt",  32'(beat_cnt), 32'd0);
        chk("rst_id",   32'(gnt_id),   32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        req   = '0;
        last  = '0;
        ack   = 1'b0;
        rst_n = 1'b1;
        model_reset();
        #2;
        do_reset();

        // single requester, last on the 3rd beat, then immediate re-grant
        for (int i = 0; i < 3; i++) step(8'h04, 8'h00, 1'b1, "single");
        step(8'h04, 8'h04, 1'b1, "single_last");
        chk("single_regrant", 32'(gnt), 32'h04);
        chk("single_ptr", 32'(dut.ptr_q), 32'd3);
        step(8'h00, 8'h00, 1'b0, "single_drop");
        step(8'h00, 8'h00, 1'b1, "idle_ack");

        // burst limit: 4 beats each, no bubble
        for (int i = 0; i < 13; i++) step(8'h03, 8'h00, 1'b1, "limit");
        step(8'h00, 8'h00, 1'b0, "limit_drop");

        // fairness from ptr=0
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(8'hFF, 8'hFF, 1'b1, "rr");
            chk("rr_seq_id", 32'(gnt_id), 32'(i % N));
        end
        step(8'h00, 8'h00, 1'b0, "rr_drop");

        // abandon: requester 5 drops after one beat while 6 waits
        do_reset();
        step(8'h20, 8'h00, 1'b0, "abn_grant");
        step(8'h60, 8'h00, 1'b1, "abn_beat");
        step(8'h40, 8'h00, 1'b1, "abn_drop");
        chk("abn_gnt6", 32'(gnt), 32'h40);
        step(8'h00, 8'h00, 1'b0, "abn_idle");

        // stall with ack low, then last beat releases
        do_reset();
        step(8'h08, 8'h00, 1'b0, "stall_grant");
        step(8'h08, 8'h00, 1'b1, "stall_beat");
        for (int i = 0; i < 10; i++) step(8'h08 | 8'h10, 8'hFF, 1'b0, "stall");
        step(8'h18, 8'h08, 1'b1, "stall_rel");
        chk("stall_next", 32'(gnt), 32'h10);
        step(8'h00, 8'h00, 1'b0, "stall_idle");

        // async reset mid burst at beat_cnt=2
        do_reset();
        step(8'h04, 8'h00, 1'b1, "ar_grant");
        step(8'h04, 8'h00, 1'b1, "ar_b1");
        step(8'h04, 8'h00, 1'b1, "ar_b2");
        chk("ar_cnt2", 32'(beat_cnt), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt",  32'(gnt),      32'd0);
        chk("ar_busy", 32'(busy),     32'd0);
        chk("ar_cnt",  32'(beat_cnt), 32'd0);
        req  = '0;
        ack  = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(8'h81, 8'h00, 1'b0, "ar_after");
        chk("ar_first", 32'(gnt), 32'h01);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(N'($urandom), N'($urandom) & N'($urandom), 1'($urandom), "rand");
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
